// File: rtl/ahb_sram_slave_if.sv
// ahb_sram_slave_if: AHB-Lite slave-port signal bundle between interconnect and memory responder
interface ahb_sram_slave_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  hsel;
    logic [ADDR_WIDTH-1:0] haddr;
    logic [1:0]            htrans;
    logic                  hwrite;
    logic [2:0]            hsize;
    logic [2:0]            hburst;
    logic [3:0]            hprot;
    logic                  hmastlock;
    logic [DATA_WIDTH-1:0] hwdata;
    logic                  hready;
    logic                  hreadyout;
    logic                  hresp;
    logic [DATA_WIDTH-1:0] hrdata;
    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hmastlock, hwdata, hready,
        input  hreadyout, hresp, hrdata
    );
    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hmastlock, hwdata, hready,
        output hreadyout, hresp, hrdata
    );
endinterface

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite responder with word-organised memory, programmable wait states and two-cycle ERROR
module ahb_sram_slave #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input logic             hclk,
    input logic             hreset,
    ahb_sram_slave_if.slave bus
);
    localparam int IW = $clog2(MEM_DEPTH);
    typedef enum logic [2:0] {IDLE, WAIT, DATA, ERR1, ERR2} state_t;
    state_t state, state_nxt;
    logic [2:0] cnt, cnt_nxt;
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic [IW-1:0] idx;
    logic [1:0] lo, size;
    logic wr, rdy, accept, illegal;
    logic [3:0] be;
    logic unused_ok;
    assign unused_ok = ^{bus.hburst, bus.hprot, bus.hmastlock};
    assign rdy = !(state == WAIT || state == ERR1);
    assign accept = rdy && bus.hsel && bus.hready && bus.htrans[1];
    assign illegal = bus.haddr >= ADDR_WIDTH'(4 * MEM_DEPTH) || bus.hsize > 3'd2 ||
                     (bus.hsize == 3'd1 && bus.haddr[0]) || (bus.hsize == 3'd2 && bus.haddr[1:0] != 2'b00);
    assign be = size == 2'd0 ? 4'b0001 << lo : size == 2'd1 ? (lo[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign bus.hreadyout = rdy;
    assign bus.hresp = state == ERR1 || state == ERR2;
    // read data comes from registered index only, so no path from haddr/hwdata
    assign bus.hrdata = state == DATA && !wr ? mem[idx] : '0;
    always_comb begin
        state_nxt = IDLE;
        cnt_nxt = '0;
        if (state == WAIT) begin
            state_nxt = cnt == '0 ? DATA : WAIT;
            cnt_nxt = cnt == '0 ? '0 : cnt - 3'd1;
        end else if (state == ERR1) begin
            state_nxt = ERR2;
        end else if (accept) begin
            state_nxt = illegal ? ERR1 : WAIT_STATES > 0 ? WAIT : DATA;
            cnt_nxt = illegal || WAIT_STATES == 0 ? '0 : 3'(WAIT_STATES - 1);
        end
    end
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state <= IDLE;
            cnt <= '0;
        end else begin
            state <= state_nxt;
            cnt <= cnt_nxt;
        end
        if (accept) begin
            idx <= bus.haddr[IW+1:2];
            lo <= bus.haddr[1:0];
            size <= bus.hsize[1:0];
            wr <= bus.hwrite;
        end
    end
    always_ff @(posedge hclk)
        if (!hreset && state == DATA && wr)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[idx][8*i +: 8] <= bus.hwdata[8*i +: 8];
endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb_ahb_sram_slave: randomized and directed checks of ahb_sram_slave against a byte-array memory model
module tb_ahb_sram_slave;
    logic hclk = 0, hreset = 1;
    always #5 hclk = ~hclk;
    logic sel3 = 0, hready_low = 0;
    logic hsel = 0, hwrite = 0;
    logic [31:0] haddr = 0, hwdata = 0;
    logic [1:0] htrans = 0;
    logic [2:0] hsize = 0;
    logic rdy, resp;
    logic [31:0] rdata;
    ahb_sram_slave_if b0 ();
    ahb_sram_slave_if b3 ();
    ahb_sram_slave #(.WAIT_STATES(0)) d0 (.hclk(hclk), .hreset(hreset), .bus(b0));
    ahb_sram_slave #(.WAIT_STATES(3)) d3 (.hclk(hclk), .hreset(hreset), .bus(b3));
    assign b0.hsel = hsel & !sel3;
    assign b3.hsel = hsel & sel3;
    assign {b0.haddr, b3.haddr} = {haddr, haddr};
    assign {b0.htrans, b3.htrans} = {htrans, htrans};
    assign {b0.hwrite, b3.hwrite} = {hwrite, hwrite};
    assign {b0.hsize, b3.hsize} = {hsize, hsize};
    assign {b0.hwdata, b3.hwdata} = {hwdata, hwdata};
    assign {b0.hburst, b3.hburst} = {3'd1, 3'd1};
    assign {b0.hprot, b3.hprot} = {4'd3, 4'd3};
    assign {b0.hmastlock, b3.hmastlock} = {1'b0, 1'b0};
    assign rdy = sel3 ? b3.hreadyout : b0.hreadyout;
    assign resp = sel3 ? b3.hresp : b0.hresp;
    assign rdata = sel3 ? b3.hrdata : b0.hrdata;
    assign b0.hready = hready_low ? 1'b0 : rdy;
    assign b3.hready = hready_low ? 1'b0 : rdy;

    typedef struct {
        logic sel;
        logic [1:0] tr;
        logic wr;
        logic [31:0] addr;
        logic [2:0] sz;
        logic [31:0] wd;
    } xfer_t;
    xfer_t q[$];
    logic [31:0] r_rdata [1024], e_rdata [1024], r_waits [1024], e_waits [1024];
    logic r_resp [1024], e_resp [1024], r_resp0 [1024], e_resp0 [1024];
    logic [7:0] mb [2][1024];
    int errors = 0, checks = 0;

    function automatic xfer_t mk(logic wr, logic [31:0] addr, logic [2:0] sz, logic [31:0] wd);
        xfer_t x;
        x.sel = 1; x.tr = 2'd2; x.wr = wr; x.addr = addr; x.sz = sz; x.wd = wd;
        return x;
    endfunction

    // Reference model: every accepted beat is judged on its own, applied in bus order
    function automatic void predict();
        int k, ws, base, w;
        bit acc, ok;
        k = sel3 ? 1 : 0;
        ws = sel3 ? 3 : 0;
        for (int i = 0; i < q.size(); i++) begin
            acc = q[i].sel && q[i].tr >= 2'd2;
            ok = q[i].addr < 32'd1024 && q[i].sz <= 3'd2 && (q[i].addr % (32'd1 << q[i].sz)) == 0;
            e_rdata[i] = 0; e_resp0[i] = 0; e_resp[i] = 0; e_waits[i] = 0;
            if (acc && !ok) begin
                e_resp0[i] = 1; e_resp[i] = 1; e_waits[i] = 1;
            end else if (acc) begin
                e_waits[i] = ws;
                base = int'(q[i].addr);
                w = base - base % 4;
                if (q[i].wr)
                    for (int b = base; b < base + (1 << q[i].sz); b++) mb[k][b] = q[i].wd[8*(b%4) +: 8];
                else
                    e_rdata[i] = {mb[k][w+3], mb[k][w+2], mb[k][w+1], mb[k][w]};
            end
        end
    endfunction

    // Pipelined AHB master: address phase of beat a overlaps data phase of beat d
    task automatic run();
        int a = 0, d = -1, waits = 0, budget = 0;
        bit first = 0;
        for (int i = 0; i < q.size(); i++) begin
            r_rdata[i] = 'x; r_resp[i] = 'x; r_resp0[i] = 'x; r_waits[i] = 'x;
        end
        while ((a < q.size() || d >= 0) && budget < 5000) begin
            @(negedge hclk);
            budget++;
            if (d >= 0) begin
                hwdata = q[d].wd;
                if (first) r_resp0[d] = resp;
                first = 0;
                if (!rdy) waits++;
                else begin
                    r_rdata[d] = rdata; r_resp[d] = resp; r_waits[d] = waits;
                end
            end
            if (a < q.size()) begin
                hsel = q[a].sel; htrans = q[a].tr; hwrite = q[a].wr; haddr = q[a].addr; hsize = q[a].sz;
            end else begin
                hsel = 0; htrans = 0;
            end
            if (rdy) begin
                d = a < q.size() ? a : -1;
                a = a < q.size() ? a + 1 : a;
                waits = 0;
                first = 1;
            end
        end
        checks++;
        if (budget >= 5000) begin
            errors++;
            $display("FAIL run_timeout: got %0d cycles, want fewer than 5000", budget);
        end
    endtask

    task automatic test_reset();
        hreset = 1;
        repeat (3) @(posedge hclk);
        @(negedge hclk);
        checks += 6;
        if (b0.hreadyout !== 1'b1) begin errors++; $display("FAIL reset_rdy0: got %b want 1", b0.hreadyout); end
        if (b0.hresp !== 1'b0) begin errors++; $display("FAIL reset_resp0: got %b want 0", b0.hresp); end
        if (b0.hrdata !== 32'h0) begin errors++; $display("FAIL reset_rdata0: got %h want 0", b0.hrdata); end
        if (b3.hreadyout !== 1'b1) begin errors++; $display("FAIL reset_rdy3: got %b want 1", b3.hreadyout); end
        if (b3.hresp !== 1'b0) begin errors++; $display("FAIL reset_resp3: got %b want 0", b3.hresp); end
        if (b3.hrdata !== 32'h0) begin errors++; $display("FAIL reset_rdata3: got %h want 0", b3.hrdata); end
        hreset = 0;
        q = {mk(1, 32'h40, 3'd2, 32'h11111111)};
        run();
        predict();
        @(negedge hclk);
        hsel = 1; htrans = 2'd2; hwrite = 1; haddr = 32'h40; hsize = 3'd2;
        @(negedge hclk);
        hsel = 0; htrans = 0; hwdata = 32'h22222222; hreset = 1;
        repeat (3) @(posedge hclk);
        @(negedge hclk);
        checks += 3;
        if (rdy !== 1'b1) begin errors++; $display("FAIL reset_mid_rdy: got %b want 1", rdy); end
        if (resp !== 1'b0) begin errors++; $display("FAIL reset_mid_resp: got %b want 0", resp); end
        if (rdata !== 32'h0) begin errors++; $display("FAIL reset_mid_rdata: got %h want 0", rdata); end
        hreset = 0;
        q = {mk(0, 32'h40, 3'd2, 32'h0)};
        run();
        predict();
        checks++;
        if (r_rdata[0] !== 32'h11111111) begin
            errors++; $display("FAIL reset_no_write: got %h want 11111111", r_rdata[0]);
        end
    endtask

    task automatic test_fill();
        q.delete();
        for (int i = 0; i < 256; i++) q.push_back(mk(1, 32'(4 * i), 3'd2, $urandom()));
        for (int i = 0; i < 256; i++) q.push_back(mk(0, 32'(4 * i), 3'd2, $urandom()));
        run();
        predict();
        for (int i = 0; i < q.size(); i++) begin
            checks++;
            if ({r_rdata[i], r_resp0[i], r_resp[i], r_waits[i]} !== {e_rdata[i], e_resp0[i], e_resp[i], e_waits[i]}) begin
                errors++;
                $display("FAIL fill[%0d]: got rdata=%h resp=%b/%b waits=%0d want rdata=%h resp=%b/%b waits=%0d",
                         i, r_rdata[i], r_resp0[i], r_resp[i], r_waits[i], e_rdata[i], e_resp0[i], e_resp[i], e_waits[i]);
            end
        end
    endtask

    task automatic test_word_raw();
        q = {mk(1, 32'h10, 3'd2, 32'hDEADBEEF), mk(0, 32'h10, 3'd2, 32'h0)};
        run();
        predict();
        checks++;
        if (r_rdata[1] !== 32'hDEADBEEF || r_waits[0] !== 0 || r_waits[1] !== 0) begin
            errors++; $display("FAIL raw_word: got %h waits=%0d/%0d want deadbeef waits=0/0", r_rdata[1], r_waits[0], r_waits[1]);
        end
        for (int i = 0; i < q.size(); i++) begin
            checks++;
            if ({r_rdata[i], r_resp0[i], r_resp[i], r_waits[i]} !== {e_rdata[i], e_resp0[i], e_resp[i], e_waits[i]}) begin
                errors++;
                $display("FAIL raw[%0d]: got rdata=%h resp=%b/%b waits=%0d want rdata=%h resp=%b/%b waits=%0d",
                         i, r_rdata[i], r_resp0[i], r_resp[i], r_waits[i], e_rdata[i], e_resp0[i], e_resp[i], e_waits[i]);
            end
        end
    endtask

    task automatic test_byte_lanes();
        q = {mk(1, 32'h20, 3'd2, 32'h0), mk(1, 32'h21, 3'd0, 32'h0000AA00),
             mk(1, 32'h22, 3'd1, 32'h12340000), mk(0, 32'h20, 3'd2, 32'h0),
             mk(1, 32'h24, 3'd1, 32'h5566FFFF), mk(1, 32'h27, 3'd0, 32'h9A000000), mk(0, 32'h24, 3'd2, 32'h0)};
        run();
        predict();
        checks++;
        if (r_rdata[3] !== 32'h1234AA00) begin
            errors++; $display("FAIL lanes_word: got %h want 1234aa00", r_rdata[3]);
        end
        for (int i = 0; i < q.size(); i++) begin
            checks++;
            if ({r_rdata[i], r_resp0[i], r_resp[i], r_waits[i]} !== {e_rdata[i], e_resp0[i], e_resp[i], e_waits[i]}) begin
                errors++;
                $display("FAIL lanes[%0d]: got rdata=%h resp=%b/%b waits=%0d want rdata=%h resp=%b/%b waits=%0d",
                         i, r_rdata[i], r_resp0[i], r_resp[i], r_waits[i], e_rdata[i], e_resp0[i], e_resp[i], e_waits[i]);
            end
        end
    endtask

    task automatic test_errors();
        q = {mk(0, 32'h400, 3'd2, 32'h0), mk(1, 32'h02, 3'd2, 32'hCAFEF00D), mk(0, 32'h08, 3'd3, 32'h0),
             mk(1, 32'h31, 3'd1, 32'h77777777), mk(1, 32'hFFFF_FFFC, 3'd2, 32'h1), mk(0, 32'h00, 3'd2, 32'h0),
             mk(0, 32'h30, 3'd2, 32'h0), mk(0, 32'h3FC, 3'd2, 32'h0)};
        run();
        predict();
        checks++;
        if ({r_resp0[0], r_resp[0], r_waits[0]} !== {1'b1, 1'b1, 32'd1}) begin
            errors++; $display("FAIL err_oob: got resp=%b/%b waits=%0d want resp=1/1 waits=1", r_resp0[0], r_resp[0], r_waits[0]);
        end
        for (int i = 0; i < q.size(); i++) begin
            checks++;
            if ({r_rdata[i], r_resp0[i], r_resp[i], r_waits[i]} !== {e_rdata[i], e_resp0[i], e_resp[i], e_waits[i]}) begin
                errors++;
                $display("FAIL err[%0d]: got rdata=%h resp=%b/%b waits=%0d want rdata=%h resp=%b/%b waits=%0d",
                         i, r_rdata[i], r_resp0[i], r_resp[i], r_waits[i], e_rdata[i], e_resp0[i], e_resp[i], e_waits[i]);
            end
        end
    endtask

    task automatic test_idle_gating();
        xfer_t x;
        q.delete();
        x = mk(1, 32'h10, 3'd2, 32'h0BAD0BAD); x.tr = 2'd0; q.push_back(x);
        x.tr = 2'd1; q.push_back(x);
        x.tr = 2'd2; x.sel = 0; q.push_back(x);
        q.push_back(mk(0, 32'h10, 3'd2, 32'h0));
        run();
        predict();
        for (int i = 0; i < q.size(); i++) begin
            checks++;
            if ({r_rdata[i], r_resp0[i], r_resp[i], r_waits[i]} !== {e_rdata[i], e_resp0[i], e_resp[i], e_waits[i]}) begin
                errors++;
                $display("FAIL idle[%0d]: got rdata=%h resp=%b/%b waits=%0d want rdata=%h resp=%b/%b waits=%0d",
                         i, r_rdata[i], r_resp0[i], r_resp[i], r_waits[i], e_rdata[i], e_resp0[i], e_resp[i], e_waits[i]);
            end
        end
        @(negedge hclk);
        hready_low = 1; hsel = 1; htrans = 2'd2; hwrite = 1; haddr = 32'h14; hsize = 3'd2; hwdata = $urandom();
        repeat (3) begin
            @(negedge hclk);
            checks++;
            if ({rdy, resp, rdata} !== {1'b1, 1'b0, 32'h0}) begin
                errors++; $display("FAIL gate_hold: got rdy=%b resp=%b rdata=%h want 1 0 0", rdy, resp, rdata);
            end
        end
        hready_low = 0; hsel = 0; htrans = 0;
        q = {mk(0, 32'h14, 3'd2, 32'h0)};
        run();
        predict();
        checks++;
        if (r_rdata[0] !== e_rdata[0]) begin
            errors++; $display("FAIL gate_no_write: got %h want %h", r_rdata[0], e_rdata[0]);
        end
    endtask

    task automatic test_wait_states();
        sel3 = 1;
        q = {mk(1, 32'h100, 3'd2, 32'hA5A5_0001), mk(1, 32'h104, 3'd2, 32'h5A5A_0002),
             mk(0, 32'h100, 3'd2, 32'h0), mk(0, 32'h104, 3'd2, 32'h0),
             mk(1, 32'h105, 3'd0, 32'h0000_EE00), mk(0, 32'h104, 3'd2, 32'h0),
             mk(0, 32'h4000, 3'd2, 32'h0), mk(0, 32'h100, 3'd2, 32'h0)};
        run();
        predict();
        checks++;
        if (r_waits[2] !== 3 || r_waits[3] !== 3) begin
            errors++; $display("FAIL ws_stall: got waits=%0d/%0d want 3/3", r_waits[2], r_waits[3]);
        end
        for (int i = 0; i < q.size(); i++) begin
            checks++;
            if ({r_rdata[i], r_resp0[i], r_resp[i], r_waits[i]} !== {e_rdata[i], e_resp0[i], e_resp[i], e_waits[i]}) begin
                errors++;
                $display("FAIL ws[%0d]: got rdata=%h resp=%b/%b waits=%0d want rdata=%h resp=%b/%b waits=%0d",
                         i, r_rdata[i], r_resp0[i], r_resp[i], r_waits[i], e_rdata[i], e_resp0[i], e_resp[i], e_waits[i]);
            end
        end
        @(negedge hclk);
        sel3 = 0;
    endtask

    task automatic test_random();
        xfer_t x;
        q.delete();
        for (int i = 0; i < 300; i++) begin
            x = mk($urandom_range(0, 1), 32'($urandom_range(0, 1023)), 3'($urandom_range(0, 2)), $urandom());
            if ($urandom_range(0, 3) != 0) x.addr = x.addr & ~((32'd1 << x.sz) - 1);
            if ($urandom_range(0, 19) == 0) x.addr = $urandom();
            if ($urandom_range(0, 19) == 0) x.addr = 32'(1024 + $urandom_range(0, 7));
            if ($urandom_range(0, 14) == 0) x.sz = 3'($urandom_range(3, 7));
            if ($urandom_range(0, 9) == 0) x.tr = 2'($urandom_range(0, 1));
            else x.tr = 2'($urandom_range(2, 3));
            if ($urandom_range(0, 14) == 0) x.sel = 0;
            q.push_back(x);
        end
        run();
        predict();
        for (int i = 0; i < q.size(); i++) begin
            checks++;
            if ({r_rdata[i], r_resp0[i], r_resp[i], r_waits[i]} !== {e_rdata[i], e_resp0[i], e_resp[i], e_waits[i]}) begin
                errors++;
                $display("FAIL rand[%0d] addr=%h sz=%0d: got rdata=%h resp=%b/%b waits=%0d want rdata=%h resp=%b/%b waits=%0d",
                         i, q[i].addr, q[i].sz, r_rdata[i], r_resp0[i], r_resp[i], r_waits[i], e_rdata[i], e_resp0[i], e_resp[i], e_waits[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_word_raw();
        test_byte_lanes();
        test_errors();
        test_idle_gating();
        test_wait_states();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
